mul_div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for DIV/DIVU, instantiated beside the EX stage.
- Runs a radix-2 restoring trial-subtraction loop, one quotient bit per cycle.
- Produces the stall request that EX forwards to the pipeline controller as its ex-stage stall request. That request freezes PC, IF, ID and EX while a divide is in flight.
- Returns {HI, LO} = {remainder, quotient} to EX for write-back.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit_div_step.sv | 30 +++
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings,
// handshake levels and the reset/zero constants reused across the core.
package mul_div_unit_pkg;

    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface mul_div_unit_if #(
    parameter int unsigned DATA_W = 32
);

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/mul_div_unit_div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the
// upper part of the working register, then shift in the quotient bit.
// Working register layout: [2W:W+1] partial remainder, [W:1] dividend /
// quotient bits in flight, [0] slot for the next quotient bit.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   divisor,
    input  logic [2*DATA_W:0]   work_in,
    output logic [2*DATA_W:0]   work_out
);

    logic [DATA_W+1:0] diff;
    logic              diff_unused;

    // The trial window is W+1 bits wide: a remainder with its MSB set,
    // shifted left, would otherwise lose a bit against a large divisor.
    assign diff_unused = diff[DATA_W];

    // Trial subtraction; a borrow means the window is smaller than the divisor.
    always_comb begin
        diff = {1'b0, work_in[2*DATA_W:DATA_W]} - {2'b00, divisor};
        if (diff[DATA_W+1]) begin
            work_out = {work_in[2*DATA_W-1:0], 1'b0};
        end else begin
            work_out = {diff[DATA_W-1:0], work_in[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle DIV/DIVU unit beside EX: one quotient bit per cycle, result
// {remainder, quotient}. Signed support is compiled in only when the macro
// MUL_DIV_UNIT_SIGNED_EN is defined; otherwise every divide is unsigned.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    mul_div_unit_if.slave     bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W:0]     work_q, work_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W-1:0]     op1_mag, op2_mag;
    logic                  op1_neg, op2_neg;
    logic [2*DATA_W:0]     step_out;
    logic [DATA_W-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;
    logic                  go;
    logic                  by_zero;

    assign go      = (bus.start_i == DivStart) && !bus.annul_i;
    assign by_zero = (bus.opdata2_i == '0);

    assign quot_raw = work_q[DATA_W-1:0];
    assign rem_raw  = work_q[2*DATA_W:DATA_W+1];

`ifdef MUL_DIV_UNIT_SIGNED_EN
    // Signed operands are divided as magnitudes and the signs restored at the end.
    always_comb begin
        op1_neg  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        op2_neg  = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        op1_mag  = op1_neg ? (~bus.opdata1_i + DATA_W'(1)) : bus.opdata1_i;
        op2_mag  = op2_neg ? (~bus.opdata2_i + DATA_W'(1)) : bus.opdata2_i;
        quot_fix = neg_quot_q ? (~quot_raw + DATA_W'(1)) : quot_raw;
        rem_fix  = neg_rem_q  ? (~rem_raw  + DATA_W'(1)) : rem_raw;
    end
`else
    logic sign_unused;
    logic fix_unused;

    assign sign_unused = bus.signed_div_i;
    assign fix_unused  = neg_quot_q ^ neg_rem_q;

    // Unsigned-only build: operands pass straight through, no fix-ups.
    always_comb begin
        op1_neg  = 1'b0;
        op2_neg  = 1'b0;
        op1_mag  = bus.opdata1_i;
        op2_mag  = bus.opdata2_i;
        quot_fix = quot_raw;
        rem_fix  = rem_raw;
    end
`endif

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .divisor  (divisor_q),
        .work_in  (work_q),
        .work_out (step_out)
    );

    // State and datapath registers; reset also aborts a divide in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (go) begin
                    state_d = by_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Datapath and output updates for the current state.
    always_comb begin
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (go && !by_zero) begin
                    cnt_d      = '0;
                    divisor_d  = op2_mag;
                    work_d     = {{DATA_W{1'b0}}, op1_mag, 1'b0};
                    neg_quot_d = op1_neg ^ op2_neg;
                    neg_rem_d  = op1_neg;
                end
            end
            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != LAST_CNT) begin
                    work_d = step_out;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a reference model (plain arithmetic
// plus a latency countdown) compared against the DUT every cycle.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.DATA_W(W)) bus ();

    mul_div_unit #(
        .DATA_W (W),
        .CNT_W  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MUL_DIV_UNIT_SIGNED_EN
    localparam logic [63:0] E_M7_2   = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    localparam logic [63:0] E_7_M2   = {32'h0000_0001, 32'hFFFF_FFFD};
    localparam logic [63:0] E_MIN_M1 = {32'h0000_0000, 32'h8000_0000};
`else
    localparam logic [63:0] E_M7_2   = {32'h0000_0001, 32'h7FFF_FFFC};
    localparam logic [63:0] E_7_M2   = {32'h0000_0007, 32'h0000_0000};
    localparam logic [63:0] E_MIN_M1 = {32'h8000_0000, 32'h0000_0000};
`endif

    // Reference result: {remainder, quotient} from magnitudes and sign rules.
    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint sa, sb, ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
`ifdef MUL_DIV_UNIT_SIGNED_EN
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
`else
        begin
            logic unused_s;
            unused_s = s;
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
`endif
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q  = ma / mb;
        r  = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Behavioural model: busy countdown of 33 edges (1 for divide by zero).
    logic        m_busy, m_bz, m_ready;
    int          m_left;
    logic [63:0] m_val, m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_bz    <= 1'b0;
            m_ready <= 1'b0;
            m_res   <= 64'd0;
            m_left  <= 0;
            m_val   <= 64'd0;
        end else if (m_ready) begin
            if (!bus.start_i) begin
                m_ready <= 1'b0;
                m_res   <= 64'd0;
            end
        end else if (m_busy) begin
            if (bus.annul_i && !m_bz) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= m_val;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.start_i && !bus.annul_i) begin
            m_busy <= 1'b1;
            m_bz   <= (bus.opdata2_i == 32'd0);
            m_left <= (bus.opdata2_i == 32'd0) ? 1 : 33;
            m_val  <= golden(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        chk("cyc_ready", {63'd0, bus.ready_o}, {63'd0, m_ready});
        chk("cyc_result", bus.result_o, m_res);
        chk("cyc_stall", {63'd0, bus.stallreq_o},
            {63'd0, bus.start_i & ~bus.annul_i & ~m_ready});
    end

    task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input int exp_lat);
        int  cyc;
        bit  got;
        @(posedge clk);
        #1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.start_i      = 1'b1;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ready_o) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: ready_o never rose, want latency %0d", nm, exp_lat);
        end else begin
            chk({nm, "_lat"}, 64'(cyc - 1), 64'(exp_lat));
            chk({nm, "_res"}, bus.result_o, exp);
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_clr"}, {63'd0, bus.ready_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;

        chk("pin_100_7", golden(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("pin_9_3", golden(32'd9, 32'd3, 1'b0), {32'd0, 32'd3});
        chk("pin_div0", golden(32'h1234_5678, 32'd0, 1'b1), 64'd0);
        chk("pin_m7_2", golden(32'hFFFF_FFF9, 32'd2, 1'b1), E_M7_2);
        chk("pin_min_m1", golden(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), E_MIN_M1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        rst = 1'b0;

        run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, E_M7_2, 33);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, E_7_M2, 33);
        run_div("div0", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, E_MIN_M1, 33);
        run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33);
        run_div("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1}, 33);
        run_div("u_fe_max", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, {32'hFFFF_FFFE, 32'd0}, 33);
        run_div("u_dead_16", 32'hDEAD_BEEF, 32'h10, 1'b0, {32'hF, 32'h0DEA_DBEE}, 33);

        // Annul at iteration 10, then a fresh request.
        @(posedge clk);
        #1;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        chk("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("annul_idle", {63'd0, bus.ready_o}, 64'd0);
        run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk);
        #1;
        bus.opdata1_i = 32'd40000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_mid_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_idle", {63'd0, bus.ready_o}, 64'd0);
        run_div("one_one", 32'd1, 32'd1, 1'b0, {32'd0, 32'd1}, 33);

        // Asynchronous reset while a result is being held.
        @(posedge clk);
        #1;
        bus.opdata1_i = 32'd20;
        bus.opdata2_i = 32'd6;
        bus.start_i   = 1'b1;
        for (int i = 0; i < 60 && !bus.ready_o; i++) begin
            @(posedge clk);
            #1;
        end
        chk("end_hold_result", bus.result_o, {32'd2, 32'd3});
        #2;
        rst = 1'b1;
        #1;
        chk("rst_end_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
